// File: rtl/alu_writeback_bc.sv
// BC register pair write-back: loads B/C from the ALU result bus, presents them
// active-low, and performs the two-cycle BC increment/decrement.
module alu_writeback_bc (
   input  logic        CLK,
   input  logic        RST,
   input  logic [15:0] Result,
   input  logic        WB_Valid,
   input  logic [2:0]  WB_Op,
   output logic        WB_Ready,
   output logic [7:0]  notB,
   output logic [7:0]  notC,
   output logic        BC_Zero
);

   localparam int unsigned BYTE_W = 8;

   typedef enum logic {
      IDLE    = 1'b0,
      PAIR_HI = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      PK_LOAD = 2'd0,
      PK_INC  = 2'd1,
      PK_DEC  = 2'd2
   } pair_kind_t;

   state_t            state_q, state_d;
   pair_kind_t        kind_q,  kind_d;
   logic [BYTE_W-1:0] b_q,     b_d;
   logic [BYTE_W-1:0] c_q,     c_d;
   logic [BYTE_W-1:0] hold_q,  hold_d;
   logic              cy_q,    cy_d;

   // Next-state: low byte and carry resolve on accept, high byte one edge later.
   always_comb begin
      state_d = state_q;
      kind_d  = kind_q;
      b_d     = b_q;
      c_d     = c_q;
      hold_d  = hold_q;
      cy_d    = cy_q;
      case (state_q)
         IDLE: begin
            if (WB_Valid) begin
               case (WB_Op)
                  3'd0: b_d = Result[7:0];
                  3'd1: c_d = Result[7:0];
                  3'd2: b_d = Result[15:8];
                  3'd3: c_d = Result[15:8];
                  3'd4: begin
                     c_d     = Result[7:0];
                     hold_d  = Result[15:8];
                     cy_d    = 1'b0;
                     kind_d  = PK_LOAD;
                     state_d = PAIR_HI;
                  end
                  3'd5: begin
                     c_d     = c_q + 8'd1;
                     hold_d  = b_q;
                     cy_d    = (c_q == 8'hFF);
                     kind_d  = PK_INC;
                     state_d = PAIR_HI;
                  end
                  3'd6: begin
                     c_d     = c_q - 8'd1;
                     hold_d  = b_q;
                     cy_d    = (c_q == 8'h00);
                     kind_d  = PK_DEC;
                     state_d = PAIR_HI;
                  end
                  default: ;
               endcase
            end
         end
         PAIR_HI: begin
            case (kind_q)
               PK_INC:  b_d = hold_q + 8'(cy_q);
               PK_DEC:  b_d = hold_q - 8'(cy_q);
               default: b_d = hold_q;
            endcase
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         kind_q  <= PK_LOAD;
         b_q     <= '0;
         c_q     <= '0;
         hold_q  <= '0;
         cy_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
         b_q     <= b_d;
         c_q     <= c_d;
         hold_q  <= hold_d;
         cy_q    <= cy_d;
      end
   end

   assign WB_Ready = (state_q == IDLE);
   assign notB     = ~b_q;
   assign notC     = ~c_q;
   assign BC_Zero  = (b_q == 8'h00) && (c_q == 8'h00);

endmodule

// File: tb/tb_alu_writeback_bc.sv
// Randomized and directed checks of alu_writeback_bc against a 16-bit pair model.
module tb_alu_writeback_bc;

   logic        CLK;
   logic        RST;
   logic [15:0] Result;
   logic        WB_Valid;
   logic [2:0]  WB_Op;
   logic        WB_Ready;
   logic [7:0]  notB;
   logic [7:0]  notC;
   logic        BC_Zero;

   alu_writeback_bc dut (
      .CLK      (CLK),
      .RST      (RST),
      .Result   (Result),
      .WB_Valid (WB_Valid),
      .WB_Op    (WB_Op),
      .WB_Ready (WB_Ready),
      .notB     (notB),
      .notC     (notC),
      .BC_Zero  (BC_Zero)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference: BC as one 16-bit number; a pair op commits its final value one edge late.
   logic [15:0] m_bc;
   logic [15:0] m_final;
   logic        m_busy;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      logic [7:0] eb;
      logic [7:0] ec;
      eb = ~m_bc[15:8];
      ec = ~m_bc[7:0];
      check("notB", 16'(notB), 16'(eb));
      check("notC", 16'(notC), 16'(ec));
      check("ready", 16'(WB_Ready), 16'(!m_busy));
      if (!m_busy)
         check("zero", 16'(BC_Zero), 16'(m_bc == 16'h0000));
   endtask

   task automatic model_edge(input logic v, input logic [2:0] op, input logic [15:0] r);
      if (m_busy) begin
         m_bc   = m_final;
         m_busy = 1'b0;
      end else if (v) begin
         case (op)
            3'd0: m_bc[15:8] = r[7:0];
            3'd1: m_bc[7:0]  = r[7:0];
            3'd2: m_bc[15:8] = r[15:8];
            3'd3: m_bc[7:0]  = r[15:8];
            3'd4, 3'd5, 3'd6: begin
               if (op == 3'd4)      m_final = r;
               else if (op == 3'd5) m_final = m_bc + 16'd1;
               else                 m_final = m_bc - 16'd1;
               m_bc[7:0] = m_final[7:0];
               m_busy    = 1'b1;
            end
            default: ;
         endcase
      end
   endtask

   // Drive one cycle of stimulus, advance one edge, check #1 after it.
   task automatic step(input logic v, input logic [2:0] op, input logic [15:0] r);
      WB_Valid = v;
      WB_Op    = op;
      Result   = r;
      @(posedge CLK);
      model_edge(v, op, r);
      #1;
      check_all();
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic pulse_reset();
      #2;
      RST = 1'b1;
      #1;
      m_bc   = 16'h0000;
      m_busy = 1'b0;
      check("rst_notB", 16'(notB), 16'h00FF);
      check("rst_notC", 16'(notC), 16'h00FF);
      check("rst_zero", 16'(BC_Zero), 16'h0001);
      check("rst_ready", 16'(WB_Ready), 16'h0001);
      #1;
      RST = 1'b0;
   endtask

   task automatic load_bc(input logic [15:0] v);
      step(1'b1, 3'd4, v);
      step(1'b0, 3'd7, 16'h0000);
   endtask

   initial begin
      m_bc     = 16'h0000;
      m_final  = 16'h0000;
      m_busy   = 1'b0;
      RST      = 1'b1;
      WB_Valid = 1'b0;
      WB_Op    = 3'd7;
      Result   = 16'h0000;
      #12;
      check_all();
      RST = 1'b0;
      @(posedge CLK);
      #1;

      // Byte writes accepted back to back.
      step(1'b1, 3'd0, 16'h00A5);
      check("b_a5", 16'(notB), 16'h005A);
      step(1'b1, 3'd3, 16'h3C00);
      check("c_3c", 16'(notC), 16'h00C3);

      // Pair write; bus changes during the high-byte cycle.
      step(1'b1, 3'd4, 16'h1234);
      check("pair_c", 16'(notC), 16'h00CB);
      check("pair_busy", 16'(WB_Ready), 16'h0000);
      step(1'b1, 3'd1, 16'hFFFF);
      check("pair_b", 16'(notB), 16'h00ED);
      check("pair_c_kept", 16'(notC), 16'h00CB);

      // Increment with carry and full wrap.
      load_bc(16'h12FF);
      step(1'b1, 3'd5, 16'h0000);
      step(1'b0, 3'd7, 16'h0000);
      check("inc_carry", {~notB, ~notC}, 16'h1300);
      load_bc(16'hFFFF);
      step(1'b1, 3'd5, 16'h0000);
      step(1'b0, 3'd7, 16'h0000);
      check("inc_wrap_zero", 16'(BC_Zero), 16'h0001);

      // Decrement with borrow and zero detect.
      step(1'b1, 3'd6, 16'h0000);
      step(1'b0, 3'd7, 16'h0000);
      check("dec_wrap", {~notB, ~notC}, 16'hFFFF);
      load_bc(16'h0001);
      step(1'b1, 3'd6, 16'h0000);
      step(1'b0, 3'd7, 16'h0000);
      check("dec_zero", 16'(BC_Zero), 16'h0001);
      load_bc(16'h0100);
      step(1'b1, 3'd6, 16'h0000);
      step(1'b0, 3'd7, 16'h0000);
      check("dec_borrow", {~notB, ~notC}, 16'h00FF);

      // Reset during the high-byte cycle aborts the pair op.
      step(1'b1, 3'd4, 16'hABCD);
      pulse_reset();
      step(1'b0, 3'd7, 16'h0000);
      check("abort_b", 16'(notB), 16'h00FF);

      // Random traffic with occasional asynchronous reset.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 49) == 0)
            pulse_reset();
         else
            step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 16'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
